// File: rtl/wr_arb_pkg.sv
// Shared types and helpers for the write-channel arbiter.
package wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // A single channel still needs a 1-bit grant index.
  function automatic int grant_width(input int ch_num);
    if (ch_num <= 1) begin
      return 1;
    end else begin
      return $clog2(ch_num);
    end
  endfunction

endpackage

// File: rtl/wr_chn_arb_rr_pick.sv
// Combinational round-robin search: first requester above last_grant, wrapping.
module rr_pick #(
  parameter int CH_NUM = 4,
  parameter int GW     = 2
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [GW-1:0]     last_grant,
  output logic [GW-1:0]     idx,
  output logic              valid
);

  int best_s;
  int dist_s;

  // Priority distance of channel j is how far it sits past last_grant; smallest wins.
  always_comb begin
    best_s = CH_NUM;
    dist_s = 0;
    idx    = '0;
    valid  = 1'b0;
    for (int j = 0; j < CH_NUM; j++) begin
      dist_s = (j + CH_NUM - 1 - int'(last_grant)) % CH_NUM;
      if (req[j] && (dist_s < best_s)) begin
        best_s = dist_s;
        idx    = GW'(j);
        valid  = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/wr_chn_arb.sv
// Round-robin arbiter multiplexing CH_NUM write channels onto one DDR write port.
// Optional watchdog on a stuck grant: define WR_ARB_TIMEOUT_EN.
module wr_chn_arb
  import wr_arb_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = 27,
  parameter int LEN_WIDTH   = 16,
  parameter int DQ_WIDTH    = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                             ddr_clk,
  input  logic                             ddr_rst,
  input  logic [CH_NUM-1:0]                ch_wreq,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]     ch_waddr,
  input  logic [CH_NUM*LEN_WIDTH-1:0]      ch_wr_len,
  input  logic [CH_NUM*8*DQ_WIDTH-1:0]     ch_wdata,
  output logic [CH_NUM-1:0]                ch_wdata_req,
  output logic [CH_NUM-1:0]                ch_wdone,
  input  logic [CH_NUM-1:0]                ch_frame_wirq,
  output logic                             ddr_wreq,
  output logic [ADDR_WIDTH-1:0]            ddr_waddr,
  output logic [LEN_WIDTH-1:0]             ddr_wr_len,
  output logic [8*DQ_WIDTH-1:0]            ddr_wdata,
  input  logic                             ddr_wrdy,
  input  logic                             ddr_wdone,
  input  logic                             ddr_wdata_req,
  output logic                             frame_wirq,
  output logic [grant_width(CH_NUM)-1:0]   grant_id,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int GW = grant_width(CH_NUM);
  localparam int DW = 8 * DQ_WIDTH;

  arb_state_t          state_r;
  arb_state_t          state_next_s;
  logic [GW-1:0]       last_grant_r;
  logic [GW-1:0]       pick_idx_s;
  logic                pick_valid_s;
  logic                grant_load_s;
  logic                burst_end_s;
  logic                tmo_hit_s;

  logic [ADDR_WIDTH-1:0] waddr_a_s [CH_NUM];
  logic [LEN_WIDTH-1:0]  len_a_s   [CH_NUM];
  logic [DW-1:0]         wdata_a_s [CH_NUM];

  for (genvar k = 0; k < CH_NUM; k++) begin : g_unpack
    assign waddr_a_s[k] = ch_waddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a_s[k]   = ch_wr_len[k*LEN_WIDTH +: LEN_WIDTH];
    assign wdata_a_s[k] = ch_wdata[k*DW +: DW];
  end

  rr_pick #(
    .CH_NUM (CH_NUM),
    .GW     (GW)
  ) u_rr_pick (
    .req        (ch_wreq),
    .last_grant (last_grant_r),
    .idx        (pick_idx_s),
    .valid      (pick_valid_s)
  );

  // Next-state logic; ddr_wrdy/ddr_wdone only matter in their own states.
  always_comb begin
    state_next_s = state_r;
    grant_load_s = 1'b0;
    burst_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_next_s = ST_REQ;
          grant_load_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (tmo_hit_s) begin
          state_next_s = ST_IDLE;
          burst_end_s  = 1'b1;
        end else if (ddr_wrdy) begin
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_DATA: begin
        if (ddr_wdone || tmo_hit_s) begin
          state_next_s = ST_IDLE;
          burst_end_s  = 1'b1;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered command outputs derived from the next state.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= GW'(CH_NUM - 1);
      grant_id     <= '0;
      ddr_wreq     <= 1'b0;
      ddr_waddr    <= '0;
      ddr_wr_len   <= '0;
      busy         <= 1'b0;
      frame_wirq   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      ddr_wreq   <= (state_next_s == ST_REQ);
      busy       <= (state_next_s != ST_IDLE);
      frame_wirq <= |ch_frame_wirq;
      if (grant_load_s) begin
        grant_id   <= pick_idx_s;
        ddr_waddr  <= waddr_a_s[pick_idx_s];
        ddr_wr_len <= len_a_s[pick_idx_s];
      end
      if (burst_end_s) begin
        last_grant_r <= grant_id;
      end
    end
  end

  // Data-phase routing to the granted channel only.
  always_comb begin
    ch_wdata_req = '0;
    ch_wdone     = '0;
    for (int j = 0; j < CH_NUM; j++) begin
      if ((state_r == ST_DATA) && (grant_id == GW'(j))) begin
        ch_wdata_req[j] = ddr_wdata_req;
        ch_wdone[j]     = ddr_wdone;
      end else begin
        ch_wdata_req[j] = 1'b0;
        ch_wdone[j]     = 1'b0;
      end
    end
  end

  assign ddr_wdata = wdata_a_s[grant_id];

`ifdef WR_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_r;

  assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == 32'(TIMEOUT_CYC - 1));

  // Watchdog: counts cycles spent holding a grant; error flag is sticky until reset.
  always_ff @(posedge ddr_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      tmo_cnt_r   <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      if ((state_r != ST_IDLE) && (state_next_s != ST_IDLE)) begin
        tmo_cnt_r <= tmo_cnt_r + 32'd1;
      end else begin
        tmo_cnt_r <= 32'd0;
      end
      if (tmo_hit_s) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit_s   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_wr_chn_arb.sv
// Directed self-checking bench for wr_chn_arb (4 channels, TIMEOUT_CYC=20).
module tb_wr_chn_arb;

  localparam int CH = 4;
  localparam int AW = 27;
  localparam int LW = 16;
  localparam int DQ = 32;
  localparam int DW = 8 * DQ;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     ch_wreq;
  logic [CH*AW-1:0]  ch_waddr;
  logic [CH*LW-1:0]  ch_wr_len;
  logic [CH*DW-1:0]  ch_wdata;
  logic [CH-1:0]     ch_wdata_req;
  logic [CH-1:0]     ch_wdone;
  logic [CH-1:0]     ch_frame_wirq;
  logic              ddr_wreq;
  logic [AW-1:0]     ddr_waddr;
  logic [LW-1:0]     ddr_wr_len;
  logic [DW-1:0]     ddr_wdata;
  logic              ddr_wrdy;
  logic              ddr_wdone;
  logic              ddr_wdata_req;
  logic              frame_wirq;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  wr_chn_arb #(
    .CH_NUM      (CH),
    .ADDR_WIDTH  (AW),
    .LEN_WIDTH   (LW),
    .DQ_WIDTH    (DQ),
    .TIMEOUT_CYC (20)
  ) dut (
    .ddr_clk       (clk),
    .ddr_rst       (rst),
    .ch_wreq       (ch_wreq),
    .ch_waddr      (ch_waddr),
    .ch_wr_len     (ch_wr_len),
    .ch_wdata      (ch_wdata),
    .ch_wdata_req  (ch_wdata_req),
    .ch_wdone      (ch_wdone),
    .ch_frame_wirq (ch_frame_wirq),
    .ddr_wreq      (ddr_wreq),
    .ddr_waddr     (ddr_waddr),
    .ddr_wr_len    (ddr_wr_len),
    .ddr_wdata     (ddr_wdata),
    .ddr_wrdy      (ddr_wrdy),
    .ddr_wdone     (ddr_wdone),
    .ddr_wdata_req (ddr_wdata_req),
    .frame_wirq    (frame_wirq),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int k);
    return 27'h100 + 27'(k) * 27'h1000;
  endfunction

  function automatic logic [DW-1:0] one_hot(input int k);
    logic [DW-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete burst for the expected grant, ending in the mandatory IDLE cycle.
  task automatic burst(input int gid);
    tick();
    check("req_gid", DW'(grant_id), DW'(gid));
    check("req_wreq", DW'(ddr_wreq), DW'(1));
    check("req_busy", DW'(busy), DW'(1));
    check("req_addr", DW'(ddr_waddr), DW'(exp_addr(gid)));
    check("req_len", DW'(ddr_wr_len), DW'(16 + gid));
    ddr_wrdy = 1'b1;
    tick();
    ddr_wrdy = 1'b0;
    check("data_wreq_low", DW'(ddr_wreq), DW'(0));
    ddr_wdata_req = 1'b1;
    #1;
    check("data_req_route", DW'(ch_wdata_req), one_hot(gid));
    check("data_mux", ddr_wdata, exp_data(gid));
    ddr_wdata_req = 1'b0;
    #1;
    check("data_req_off", DW'(ch_wdata_req), DW'(0));
    ddr_wdone = 1'b1;
    #1;
    check("done_route", DW'(ch_wdone), one_hot(gid));
    tick();
    ddr_wdone = 1'b0;
    check("idle_gap_busy", DW'(busy), DW'(0));
    check("idle_gap_wreq", DW'(ddr_wreq), DW'(0));
  endtask

  initial begin
    rst = 1'b1;
    ch_wreq = '0;
    ch_frame_wirq = '0;
    ddr_wrdy = 1'b0;
    ddr_wdone = 1'b0;
    ddr_wdata_req = 1'b0;
    for (int k = 0; k < CH; k++) begin
      ch_waddr[k*AW +: AW]  = exp_addr(k);
      ch_wr_len[k*LW +: LW] = LW'(16 + k);
      ch_wdata[k*DW +: DW]  = exp_data(k);
    end

    tick();
    tick();
    check("rst_wreq", DW'(ddr_wreq), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_gid", DW'(grant_id), DW'(0));
    check("rst_addr", DW'(ddr_waddr), DW'(0));
    check("rst_len", DW'(ddr_wr_len), DW'(0));
    check("rst_irq", DW'(frame_wirq), DW'(0));
    check("rst_tmo", DW'(timeout_err), DW'(0));
    rst = 1'b0;
    tick();

    // Single request on channel 0: one cycle of latency to ddr_wreq.
    ch_wreq = 4'b0001;
    #1;
    check("wreq_latency", DW'(ddr_wreq), DW'(0));
    burst(0);
    ch_wreq = 4'b0000;

    // Dropping the request after REQ is entered must not abort the grant.
    ch_wreq = 4'b0100;
    tick();
    check("abort_gid", DW'(grant_id), DW'(2));
    ch_wreq = 4'b0000;
    tick();
    check("no_abort_busy", DW'(busy), DW'(1));
    check("no_abort_wreq", DW'(ddr_wreq), DW'(1));
    ddr_wrdy = 1'b1;
    tick();
    ddr_wrdy = 1'b0;
    ddr_wdone = 1'b1;
    #1;
    check("no_abort_done", DW'(ch_wdone), DW'(4'b0100));
    tick();
    ddr_wdone = 1'b0;

    // Fresh reset, then all channels requesting: 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    ch_wreq = 4'b1111;
    burst(0);
    burst(1);
    burst(2);
    burst(3);
    burst(0);
    ch_wreq = 4'b0000;

    // Stray handshakes while idle are ignored.
    ddr_wdone = 1'b1;
    #1;
    check("stray_done", DW'(ch_wdone), DW'(0));
    ddr_wrdy = 1'b1;
    tick();
    check("stray_busy", DW'(busy), DW'(0));
    check("stray_wreq", DW'(ddr_wreq), DW'(0));
    ddr_wrdy = 1'b0;
    ddr_wdone = 1'b0;

    // Frame interrupt is registered.
    ch_frame_wirq = 4'b1000;
    #1;
    check("irq_not_yet", DW'(frame_wirq), DW'(0));
    tick();
    check("irq_high", DW'(frame_wirq), DW'(1));
    ch_frame_wirq = 4'b0000;
    tick();
    check("irq_low", DW'(frame_wirq), DW'(0));

    // Reset in the data phase abandons the burst without a done pulse.
    ch_wreq = 4'b0010;
    tick();
    check("mid_gid", DW'(grant_id), DW'(1));
    ddr_wrdy = 1'b1;
    tick();
    ddr_wrdy = 1'b0;
    ddr_wdone = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_done", DW'(ch_wdone), DW'(0));
    check("mid_rst_busy", DW'(busy), DW'(0));
    check("mid_rst_gid", DW'(grant_id), DW'(0));
    ddr_wdone = 1'b0;
    ch_wreq = 4'b0000;
    tick();
    rst = 1'b0;
    tick();

    // Withheld ddr_wrdy.
    ch_wreq = 4'b0001;
    tick();
    check("stall_gid", DW'(grant_id), DW'(0));
`ifdef WR_ARB_TIMEOUT_EN
    repeat (19) tick();
    check("tmo_still_busy", DW'(busy), DW'(1));
    check("tmo_not_yet", DW'(timeout_err), DW'(0));
    tick();
    ch_wreq = 4'b0000;
    check("tmo_idle", DW'(busy), DW'(0));
    check("tmo_err", DW'(timeout_err), DW'(1));
    repeat (3) tick();
    check("tmo_sticky", DW'(timeout_err), DW'(1));
    rst = 1'b1;
    tick();
    check("tmo_cleared", DW'(timeout_err), DW'(0));
    rst = 1'b0;
    tick();
`else
    repeat (25) tick();
    check("stall_busy", DW'(busy), DW'(1));
    check("stall_wreq", DW'(ddr_wreq), DW'(1));
    check("stall_no_tmo", DW'(timeout_err), DW'(0));
    ch_wreq = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wr_chn_arb.md
WR_CHN_ARB -- requirements
Module: wr_chn_arb

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of write channels (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 27, DDR address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, burst length width.
REQ-004 SHALL have parameter DQ_WIDTH, default 32; data bus is 8*DQ_WIDTH.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535, watchdog limit (used only under WR_ARB_TIMEOUT_EN).
REQ-006 SHALL have one clock and an asynchronous, active-high reset: ddr_clk input 1 (all logic, rising edge) and ddr_rst input 1.
REQ-007 SHALL have ch_wreq input CH_NUM: per-channel write request, level, held until done.
REQ-008 SHALL have ch_waddr input CH_NUM*ADDR_WIDTH: flattened per-channel address; channel k at [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have ch_wr_len input CH_NUM*LEN_WIDTH: flattened per-channel burst length.
REQ-010 SHALL have ch_wdata input CH_NUM*8*DQ_WIDTH: flattened per-channel write data.
REQ-011 SHALL have ch_wdata_req output CH_NUM: data request routed to the granted channel.
REQ-012 SHALL have ch_wdone output CH_NUM: done pulse routed to the granted channel.
REQ-013 SHALL have ch_frame_wirq input CH_NUM: per-channel frame interrupts.
REQ-014 SHALL have ddr_wreq output 1, ddr_waddr output ADDR_WIDTH, ddr_wr_len output LEN_WIDTH and ddr_wdata output 8*DQ_WIDTH toward the DDR write port.
REQ-015 SHALL have ddr_wrdy input 1 (command accepted), ddr_wdone input 1 (burst complete) and ddr_wdata_req input 1 (data request).
REQ-016 SHALL have frame_wirq output 1, grant_id output $clog2(CH_NUM) (min 1), busy output 1 and timeout_err output 1.

Function
REQ-017 SHALL implement FSM IDLE->REQ->DATA->IDLE.
REQ-018 IDLE: if any ch_wreq is high, SHALL select the first requesting channel searching upward from last_grant+1 (mod CH_NUM), latch grant_id, ddr_waddr and ddr_wr_len, and enter REQ; ddr_wreq is high from the next cycle (1-cycle latency).
REQ-019 REQ: ddr_wreq SHALL be 1; on ddr_wrdy it SHALL deassert the following cycle and the FSM SHALL enter DATA.
REQ-020 DATA: ch_wdata_req[grant_id] SHALL equal ddr_wdata_req combinationally, ddr_wdata SHALL equal ch_wdata of grant_id combinationally, and all other ch_wdata_req bits SHALL be 0.
REQ-021 DATA: on ddr_wdone, ch_wdone[grant_id] SHALL pulse for the same cycle, last_grant SHALL become grant_id, and the FSM SHALL return to IDLE.
REQ-022 SHALL insert one IDLE cycle between consecutive grants, even when requests are pending.
REQ-023 Once REQ is entered, a deassertion of ch_wreq SHALL NOT abort the grant.
REQ-024 ddr_wrdy outside REQ and ddr_wdone outside DATA SHALL be ignored.
REQ-025 frame_wirq SHALL be the OR of ch_frame_wirq, registered (1-cycle latency).
REQ-026 busy SHALL be 1 in REQ and DATA.
REQ-027 With CH_NUM=1, the block SHALL act as a pass-through with the same FSM timing.

Reset
REQ-028 On ddr_rst, the block SHALL go to IDLE with ddr_wreq, busy, frame_wirq, timeout_err, ddr_waddr, ddr_wr_len and grant_id all 0, and last_grant = CH_NUM-1 (channel 0 wins first).
REQ-029 A reset mid-burst SHALL abandon the grant immediately, with no ch_wdone pulse.

Configuration
REQ-030 With WR_ARB_TIMEOUT_EN defined, a counter SHALL run in REQ/DATA; on reaching TIMEOUT_CYC the FSM SHALL return to IDLE, update last_grant, and set timeout_err sticky until reset.
REQ-031 Without WR_ARB_TIMEOUT_EN, there SHALL be no counter, and timeout_err SHALL be tied to 0.

Structure
REQ-032 Package wr_arb_pkg SHALL hold the FSM state typedef and the grant-width function.
REQ-033 Sub-module rr_pick SHALL contain the combinational round-robin search (inputs: req vector, last_grant; outputs: index, valid).

Verification
REQ-034 Reset, then ch_wreq=4'b0001, addr0=0x100, len0=16 -> ddr_wreq high 1 cycle after request; ddr_waddr=0x100, ddr_wr_len=16, grant_id=0.
REQ-035 ch_wreq=4'b1111 held, each burst completed -> grants in order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-036 Channel 2 in DATA, ddr_wdata_req pulsed -> only ch_wdata_req[2] toggles; ddr_wdata equals ch_wdata[2]; ddr_wdone -> only ch_wdone[2] pulses.
REQ-037 ch_frame_wirq[3] pulse -> frame_wirq pulses 1 cycle later; stray ddr_wdone in IDLE -> no ch_wdone.
REQ-038 With WR_ARB_TIMEOUT_EN and TIMEOUT_CYC=20, ddr_wrdy withheld -> IDLE after 20 cycles, timeout_err=1 until ddr_rst.
